// File: rtl/mspeckey_pkg.sv
// Shared definitions for the mSPECKEY round controller: block geometry,
// controller FSM state encoding and the inter-round lane rotation helper.
package mspeckey_pkg;

   localparam int LANE_W    = 16;
   localparam int NUM_LANES = 8;
   localparam int BLOCK_W   = 128;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } ctrl_state_t;

   // Rotate the block up by one lane: lane i moves to lane i+1, the top lane wraps to lane 0.
   function automatic logic [BLOCK_W-1:0] lane_rot(input logic [BLOCK_W-1:0] w);
      return {w[BLOCK_W-LANE_W-1:0], w[BLOCK_W-1:BLOCK_W-LANE_W]};
   endfunction

endpackage

// File: rtl/mSPECKEY_enc_warx.sv
// Combinational 128-bit mSPECKEY encoding layer: eight independent 16-bit
// mSPECKEY_enc lanes. Each lane is a SPECK-style ARX round on two bytes
// (x = hi byte, y = lo byte) with a fixed per-lane key byte:
//    x' = ror8(x, 7) + y ; x'' = x' ^ key[lane] ; y' = rol8(y, 2) ^ x''
module mSPECKEY_enc_warx
   import mspeckey_pkg::*;
(
   input  logic [BLOCK_W-1:0] data_i,
   output logic [BLOCK_W-1:0] data_o
);

   genvar gi;
   generate
      for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
         localparam logic [7:0] LANE_KEY = 8'h3C ^ 8'(gi);

         logic [7:0] x_in;
         logic [7:0] y_in;
         logic [7:0] x_add;
         logic [7:0] x_out;
         logic [7:0] y_out;

         assign x_in  = data_i[gi*LANE_W+15 -: 8];
         assign y_in  = data_i[gi*LANE_W+7  -: 8];
         assign x_add = {x_in[6:0], x_in[7]} + y_in;
         assign x_out = x_add ^ LANE_KEY;
         assign y_out = {y_in[5:0], y_in[7:6]} ^ x_out;

         assign data_o[gi*LANE_W +: LANE_W] = {x_out, y_out};
      end
   endgenerate

endmodule

// File: rtl/mspeckey_round_ctrl.sv
// Iterative mSPECKEY round sequencer: accepts one 128-bit block, applies the
// encoding layer NUM_ROUNDS times (one round per clock) through a single
// layer instance, then presents the result until downstream takes it.
// Optional feature macro: MSPECKEY_CTRL_LANE_ROT_EN enables a one-lane
// rotation after every round except the last.
module mspeckey_round_ctrl
   import mspeckey_pkg::*;
#(
   parameter int NUM_ROUNDS = 16
)(
   input  logic               clk,
   input  logic               rst,
   input  logic               clear,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [BLOCK_W-1:0] in_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [BLOCK_W-1:0] out_data,
   output logic               busy,
   output logic [7:0]         round_idx
);

   localparam logic [7:0] LAST_IDX = 8'(NUM_ROUNDS - 1);

   ctrl_state_t        state_q, state_d;
   logic [BLOCK_W-1:0] data_q, data_d;
   logic [7:0]         round_q, round_d;
   logic [BLOCK_W-1:0] layer_out;
   logic [BLOCK_W-1:0] mixed;

   mSPECKEY_enc_warx u_layer (
      .data_i (data_q),
      .data_o (layer_out)
   );

`ifdef MSPECKEY_CTRL_LANE_ROT_EN
   assign mixed = lane_rot(layer_out);
`else
   assign mixed = layer_out;
`endif

   // State, data and round counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         data_q  <= '0;
         round_q <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         round_q <= round_d;
      end
   end

   // Next-state logic; clear overrides every transition but keeps the data register.
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      round_d = round_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               data_d  = in_data;
               round_d = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            round_d = round_q + 8'd1;
            if (round_q == LAST_IDX) begin
               data_d  = layer_out;
               state_d = DONE;
            end else begin
               data_d  = mixed;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
               round_d = '0;
            end
         end
         default: begin
            state_d = IDLE;
            round_d = '0;
         end
      endcase
      if (clear) begin
         state_d = IDLE;
         round_d = '0;
         data_d  = data_q;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q == RUN) || (state_q == DONE);
   assign out_data  = data_q;
   assign round_idx = round_q;

endmodule

// File: doc/mspeckey_round_ctrl.md
# mspeckey_round_ctrl

Iterative sequencer for the 128-bit white-box mSPECKEY encoding layer (`mSPECKEY_enc_warx`: eight parallel 16-bit `mSPECKEY_enc` lanes). It accepts one 128-bit block over a valid/ready handshake and applies the layer `NUM_ROUNDS` times, one round per clock, reusing a single layer instance. An optional lane rotation between rounds provides diffusion across lanes. The block sits between the white-box input encoding stage and the output stage of the WBC encryption pipeline.

## Interface
- `NUM_ROUNDS`, default 16: number of layer applications per block; legal range 1..255.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `clear`  in  1  synchronous abort; returns the block to IDLE.
- `in_valid`  in  1  input block present.
- `in_ready`  out  1  block can accept input; high only in IDLE.
- `in_data`  in  128  input block; lane i occupies bits [16i+15:16i].
- `out_valid`  out  1  result present; high only in DONE.
- `out_ready`  in  1  downstream accepts the result.
- `out_data`  out  128  result block; valid while `out_valid` is high.
- `busy`  out  1  high in RUN or DONE.
- `round_idx`  out  8  index of the round applied on the next RUN edge.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE: `in_ready`=1. When `in_valid`=1, capture `state <= in_data` and `round_idx <= 0`, then go to RUN.
  - RUN: each cycle, `state <= mix(warx(state))` and `round_idx++`. When `round_idx == NUM_ROUNDS-1`, apply the final round without mix and go to DONE.
  - DONE: `out_valid`=1 and `out_data=state`. When `out_ready`=1, go to IDLE.
- `warx` is the combinational `mSPECKEY_enc_warx` function applied to the full 128-bit word.
- `mix` (only when the macro is defined): lane rotate up by one. `next[127:16]=w[111:0]`, `next[15:0]=w[127:112]`.
- `out_data` is the `state` register directly. It holds its value in DONE regardless of `out_ready`; it is not cleared on exit.
- `round_idx` is 8 bits wide, compared against `NUM_ROUNDS-1` and never wraps. It reads 0 in IDLE and `NUM_ROUNDS` in DONE.
- `NUM_ROUNDS=1`: RUN lasts exactly one cycle, and that single round has no mix.
- `clear`=1 takes priority over every transition. It forces IDLE and `round_idx=0`; `state` is retained. An input presented in the same cycle as `clear` is not accepted.
- An `in_valid` that arrives during RUN or DONE is held off by `in_ready`=0. Nothing is dropped or overwritten.
- `rst` asserted mid-operation discards the block in flight. There is no partial output.

## Timing
- Reset values: state=IDLE, `state` reg=0, `round_idx`=0, `in_ready`=1, `out_valid`=0, `busy`=0, `out_data`=0.
- Accept handshake at edge k. `out_valid` rises after edge k+NUM_ROUNDS, giving a latency of NUM_ROUNDS cycles.
- Minimum spacing between accepts is NUM_ROUNDS+2 edges when `out_ready` is held at 1: NUM_ROUNDS RUN edges, one DONE edge, then one IDLE edge to accept.
- All outputs are registered-state decodes. There is no combinational path from `in_valid` or `out_ready` to any output.
- The critical path is one `warx` evaluation plus the mix wiring plus the state mux.

## Configuration
- `MSPECKEY_CTRL_LANE_ROT_EN` defined: the `mix` lane rotation is applied after every round except the last.
- Macro undefined: `mix` is the identity, so the result is the layer applied NUM_ROUNDS times lane-wise. Lanes stay independent.

## Structure
- Shared package `mspeckey_pkg` holds:
  - `LANE_W`=16, `NUM_LANES`=8, `BLOCK_W`=128;
  - the FSM state enum `ctrl_state_t` (IDLE/RUN/DONE);
  - a `lane_rot` function.
- One sub-module: the existing `mSPECKEY_enc_warx` instance (`u_layer`) as the combinational round datapath. The FSM and registers live in `mspeckey_round_ctrl`.

## Test plan
- Reset with `rst` pulsed mid-RUN → all outputs return to their reset values immediately; the next accept proceeds normally.
- NUM_ROUNDS=16, `in_data`=128'h0 accepted at edge k, `out_ready`=1 → `out_valid` high for exactly one cycle after edge k+16. `out_data` equals the software model (`warx`, plus rot with the macro) chained 16 times.
- `out_ready` held at 0 for 5 cycles in DONE → `out_valid`/`out_data` stable; `in_ready`=0 throughout; `in_valid` held high is not consumed until one cycle after DONE exits.
- `clear` pulsed at `round_idx`=7 with `in_valid`=1 → IDLE next cycle, no `out_valid`, input not accepted that cycle; the same block is accepted on the following cycle.
- NUM_ROUNDS=1, `in_data`=128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210 → `out_valid` after one cycle; `out_data` = `warx(in)` with no rotation, even with the macro defined.
- Back-to-back: 4 blocks streamed with `in_valid`/`out_ready` tied high → accepts exactly 18 cycles apart for NUM_ROUNDS=16; outputs appear in order and match the model.
